// File: rtl/register_file_scoreboard.sv
// Parametrised register file with combinational read ports, same-cycle
// write-to-read bypass, optional hardwired-zero register and a per-register
// pending scoreboard with a population counter for hazard stalls.

// One combinational read port: data and busy lookup with bypass override.
module register_file_scoreboard_rd #(
    parameter int XLEN      = 32,
    parameter int REG_COUNT = 32,
    parameter int AW        = 5,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1
) (
    input  logic [AW-1:0]                    addr,
    input  logic [REG_COUNT-1:0][XLEN-1:0]   regs,
    input  logic [REG_COUNT-1:0]             busy,
    input  logic                             wr_ok,
    input  logic [AW-1:0]                    c_address,
    input  logic [XLEN-1:0]                  c_in,
    output logic [XLEN-1:0]                  data,
    output logic                             busy_out
);
    localparam logic [AW:0] LIMIT = (AW+1)'(REG_COUNT);

    logic ok;
    logic hit;

    // Address must be in range and not the hardwired-zero register; a hit
    // means the writeback this cycle targets the same register.
    always_comb begin
        ok       = ({1'b0, addr} < LIMIT) && !((ZERO_REG != 0) && (addr == '0));
        hit      = (BYPASS != 0) && wr_ok && (c_address == addr);
        data     = '0;
        busy_out = 1'b0;
        if (ok) begin
            data     = hit ? c_in : regs[addr];
            busy_out = !hit && busy[addr];
        end
    end
endmodule

module register_file_scoreboard #(
    parameter int XLEN       = 32,
    parameter int REG_COUNT  = 32,
    parameter int READ_PORTS = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1,
    localparam int AW        = $clog2(REG_COUNT),
    localparam int CW        = $clog2(REG_COUNT + 1)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         write,
    input  logic [AW-1:0]                c_address,
    input  logic [XLEN-1:0]              c_in,
    input  logic                         reserve,
    input  logic [AW-1:0]                reserve_address,
    input  logic [READ_PORTS*AW-1:0]     read_addresses,
    output logic [READ_PORTS*XLEN-1:0]   read_data,
    output logic [READ_PORTS-1:0]        read_busy,
    output logic [CW-1:0]                busy_count
);
    localparam logic [AW:0] LIMIT = (AW+1)'(REG_COUNT);

    logic [REG_COUNT-1:0][XLEN-1:0] regs;
    logic [REG_COUNT-1:0]           busy;
    logic [REG_COUNT-1:0]           busy_nxt;
    logic                           wr_ok;
    logic                           rs_ok;
    logic                           set_new;
    logic                           clr_new;

    function automatic logic writable(input logic [AW-1:0] a);
        return ({1'b0, a} < LIMIT) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    // Qualified write/reserve; gating with reset keeps bypass from leaking
    // c_in onto read_data while reset is held.
    always_comb begin
        wr_ok    = reset && write && writable(c_address);
        rs_ok    = reset && reserve && writable(reserve_address);
        busy_nxt = busy;
        if (wr_ok) busy_nxt[c_address] = 1'b0;
        if (rs_ok) busy_nxt[reserve_address] = 1'b1;
        // A reserve of the register being released re-arms it: no net change.
        set_new  = rs_ok && !busy[reserve_address];
        clr_new  = wr_ok && busy[c_address] &&
                   !(rs_ok && (reserve_address == c_address));
    end

    // Register array: writeback store, zeroed by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) regs <= '0;
        else if (wr_ok) regs[c_address] <= c_in;
    end

    // Scoreboard bits and their population counter, updated incrementally.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy <= busy_nxt;
            if (set_new && !clr_new)      busy_count <= busy_count + CW'(1);
            else if (clr_new && !set_new) busy_count <= busy_count - CW'(1);
        end
    end

    genvar p;
    generate
        for (p = 0; p < READ_PORTS; p++) begin : g_rd
            register_file_scoreboard_rd #(
                .XLEN(XLEN), .REG_COUNT(REG_COUNT), .AW(AW),
                .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
            ) u_rd (
                .addr      (read_addresses[p*AW +: AW]),
                .regs      (regs),
                .busy      (busy),
                .wr_ok     (wr_ok),
                .c_address (c_address),
                .c_in      (c_in),
                .data      (read_data[p*XLEN +: XLEN]),
                .busy_out  (read_busy[p])
            );
        end
    endgenerate
endmodule

// File: tb/tb_register_file_scoreboard.sv
// Bench for register_file_scoreboard: two instances (bypass on / off) share
// stimulus and are checked against an array-based reference model.
module tb_register_file_scoreboard;
    localparam int XLEN = 32;
    localparam int RC   = 32;
    localparam int RP   = 2;
    localparam int AW   = 5;
    localparam int CW   = 6;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              write = 1'b0;
    logic [AW-1:0]     c_address = '0;
    logic [XLEN-1:0]   c_in = '0;
    logic              reserve = 1'b0;
    logic [AW-1:0]     reserve_address = '0;
    logic [RP*AW-1:0]  read_addresses = '0;
    logic [RP*XLEN-1:0] rd, rd_nb;
    logic [RP-1:0]     rb, rb_nb;
    logic [CW-1:0]     bc, bc_nb;

    logic [XLEN-1:0] m_reg [RC];
    bit              m_busy [RC];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    register_file_scoreboard #(.BYPASS(1)) dut (
        .clock(clock), .reset(reset), .write(write), .c_address(c_address),
        .c_in(c_in), .reserve(reserve), .reserve_address(reserve_address),
        .read_addresses(read_addresses), .read_data(rd), .read_busy(rb),
        .busy_count(bc));

    register_file_scoreboard #(.BYPASS(0)) dut_nb (
        .clock(clock), .reset(reset), .write(write), .c_address(c_address),
        .c_in(c_in), .reserve(reserve), .reserve_address(reserve_address),
        .read_addresses(read_addresses), .read_data(rd_nb), .read_busy(rb_nb),
        .busy_count(bc_nb));

    // ---------------- reference model ----------------
    function automatic logic [XLEN-1:0] exp_rd(int a, bit byp);
        if (!reset || a == 0) return '0;
        if (byp && write && int'(c_address) == a) return c_in;
        return m_reg[a];
    endfunction

    function automatic bit exp_bsy(int a, bit byp);
        if (!reset || a == 0) return 1'b0;
        if (byp && write && int'(c_address) == a) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic int exp_cnt();
        int n = 0;
        if (!reset) return 0;
        for (int i = 0; i < RC; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    function automatic int port_addr(int p);
        logic [AW-1:0] a;
        a = read_addresses[p*AW +: AW];
        return int'(a);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < RC; i++) begin m_reg[i] = '0; m_busy[i] = 1'b0; end
    endtask

    task automatic model_edge();
        if (!reset) begin model_reset(); return; end
        if (write && c_address != 0) begin
            m_reg[c_address]  = c_in;
            m_busy[c_address] = 1'b0;
        end
        if (reserve && reserve_address != 0) m_busy[reserve_address] = 1'b1;
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic set_ra(int p, int a);
        read_addresses[p*AW +: AW] = AW'(a);
    endtask

    task automatic idle();
        write = 1'b0; reserve = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int a;
        model_reset();
        #1;
        n_checks++;
        if (rd !== '0 || rb !== '0 || bc !== '0) begin
            n_fail++; $display("FAIL reset_initial rd=%h rb=%b bc=%0d want 0", rd, rb, bc);
        end
        tick(); tick();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            write = 1'b1; c_address = AW'($urandom_range(1, RC-1)); c_in = $urandom;
            reserve = 1'b1; reserve_address = AW'($urandom_range(1, RC-1));
            tick();
        end
        // assert mid-cycle with write still active on a read address
        a = int'(c_address);
        set_ra(0, a); set_ra(1, int'(reserve_address));
        reset = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (rd !== '0 || rb !== '0 || bc !== '0 || bc_nb !== '0) begin
            n_fail++; $display("FAIL reset_async rd=%h rb=%b bc=%0d want 0", rd, rb, bc);
        end
        tick(); tick();
        idle();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_ra(0, i * 8 + 1); set_ra(1, i * 8 + 3);
            #1;
            n_checks++;
            if (rd !== '0 || rb !== '0 || bc !== '0) begin
                n_fail++; $display("FAIL reset_after rd=%h rb=%b bc=%0d want 0", rd, rb, bc);
            end
        end
        tick();
    endtask

    task automatic test_write_read();
        write = 1'b1; c_address = 5; c_in = 32'hDEADBEEF;
        tick();
        idle(); set_ra(0, 5); set_ra(1, 5);
        @(negedge clock);
        n_checks++;
        if (rd !== {2{32'hDEADBEEF}} || rd_nb !== {2{32'hDEADBEEF}}) begin
            n_fail++; $display("FAIL write_read_r5 got %h / %h want deadbeef x2", rd, rd_nb);
        end
        write = 1'b1; c_address = 0; c_in = 32'h12345678;
        set_ra(0, 0); set_ra(1, 0);
        #1;
        n_checks++;
        if (rd !== '0) begin
            n_fail++; $display("FAIL zero_reg_bypass got %h want 0", rd);
        end
        tick();
        idle();
        @(negedge clock);
        n_checks++;
        if (rd !== '0 || rd_nb !== '0) begin
            n_fail++; $display("FAIL zero_reg_write got %h / %h want 0", rd, rd_nb);
        end
        tick();
    endtask

    task automatic test_bypass();
        write = 1'b1; c_address = 10; c_in = 32'h0BAD_F00D;
        tick();
        c_in = 32'hCAFEBABE; set_ra(0, 10); set_ra(1, 10);
        @(negedge clock);
        n_checks++;
        if (rd[31:0] !== 32'hCAFEBABE) begin
            n_fail++; $display("FAIL bypass_on got %h want cafebabe", rd[31:0]);
        end
        n_checks++;
        if (rd_nb[31:0] !== 32'h0BADF00D) begin
            n_fail++; $display("FAIL bypass_off_old got %h want 0badf00d", rd_nb[31:0]);
        end
        tick();
        idle();
        @(negedge clock);
        n_checks++;
        if (rd_nb[31:0] !== 32'hCAFEBABE || rd[31:0] !== 32'hCAFEBABE) begin
            n_fail++; $display("FAIL bypass_off_new got %h / %h want cafebabe", rd_nb[31:0], rd[31:0]);
        end
        tick();
    endtask

    task automatic test_scoreboard();
        reserve = 1'b1; reserve_address = 3;
        tick();
        idle(); set_ra(0, 3); set_ra(1, 4);
        @(negedge clock);
        n_checks++;
        if (rb !== 2'b01 || bc !== 6'd1) begin
            n_fail++; $display("FAIL reserve_r3 rb=%b bc=%0d want 01 / 1", rb, bc);
        end
        write = 1'b1; c_address = 3; c_in = 32'h3;
        #1;
        n_checks++;
        if (rb[0] !== 1'b0 || rb_nb[0] !== 1'b1) begin
            n_fail++; $display("FAIL release_bypass rb=%b rb_nb=%b want 0 / 1", rb[0], rb_nb[0]);
        end
        tick();
        idle();
        @(negedge clock);
        n_checks++;
        if (bc !== 6'd0 || rb[0] !== 1'b0 || bc_nb !== 6'd0) begin
            n_fail++; $display("FAIL release_count bc=%0d rb=%b want 0", bc, rb[0]);
        end
        tick();
    endtask

    task automatic test_same_cycle();
        reserve = 1'b1; reserve_address = 7;
        tick();
        write = 1'b1; c_address = 7; c_in = 32'h77;
        reserve = 1'b1; reserve_address = 7;
        tick();
        idle(); set_ra(0, 7); set_ra(1, 8);
        @(negedge clock);
        n_checks++;
        if (rb !== 2'b01 || bc !== 6'd1) begin
            n_fail++; $display("FAIL same_addr rb=%b bc=%0d want 01 / 1", rb, bc);
        end
        write = 1'b1; c_address = 7; c_in = 32'h78;
        reserve = 1'b1; reserve_address = 8;
        tick();
        idle();
        @(negedge clock);
        n_checks++;
        if (rb !== 2'b10 || bc !== 6'd1 || rd[31:0] !== 32'h78) begin
            n_fail++; $display("FAIL swap_addr rb=%b bc=%0d rd0=%h want 10 / 1 / 78", rb, bc, rd[31:0]);
        end
        write = 1'b1; c_address = 8;
        tick(); idle();
        @(negedge clock);
        n_checks++;
        if (bc !== 6'd0) begin
            n_fail++; $display("FAIL clear_r8 bc=%0d want 0", bc);
        end
        tick();
    endtask

    task automatic test_fill();
        for (int i = 1; i < RC; i++) begin
            reserve = 1'b1; reserve_address = AW'(i);
            tick();
        end
        idle();
        @(negedge clock);
        n_checks++;
        if (bc !== 6'd31 || bc_nb !== 6'd31) begin
            n_fail++; $display("FAIL fill_count bc=%0d want 31", bc);
        end
        reserve = 1'b1; reserve_address = 0;
        tick();
        reserve_address = 12;
        tick();
        idle(); set_ra(0, 0); set_ra(1, 31);
        @(negedge clock);
        n_checks++;
        if (bc !== 6'd31 || rb !== 2'b10) begin
            n_fail++; $display("FAIL fill_r0 bc=%0d rb=%b want 31 / 10", bc, rb);
        end
        reserve = 1'b1; reserve_address = 9;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (bc !== 6'd0 || bc_nb !== 6'd0 || rb !== '0) begin
            n_fail++; $display("FAIL fill_reset bc=%0d rb=%b want 0", bc, rb);
        end
        #1 reset = 1'b1;
        idle();
        tick();
    endtask

    task automatic test_random();
        int a;
        for (int cyc = 0; cyc < 300; cyc++) begin
            write = 1'($urandom_range(0, 1));
            c_address = AW'($urandom_range(0, 11));
            c_in = $urandom;
            reserve = 1'($urandom_range(0, 1));
            reserve_address = AW'($urandom_range(0, 11));
            for (int p = 0; p < RP; p++)
                set_ra(p, ($urandom_range(0, 3) == 0) ? int'(c_address) : int'($urandom_range(0, 11)));
            @(negedge clock);
            for (int p = 0; p < RP; p++) begin
                a = port_addr(p);
                n_checks++;
                if (rd[p*XLEN +: XLEN] !== exp_rd(a, 1) || rb[p] !== exp_bsy(a, 1)) begin
                    n_fail++;
                    $display("FAIL rand_byp cyc=%0d p=%0d a=%0d got %h/%b want %h/%b",
                             cyc, p, a, rd[p*XLEN +: XLEN], rb[p], exp_rd(a, 1), exp_bsy(a, 1));
                end
                n_checks++;
                if (rd_nb[p*XLEN +: XLEN] !== exp_rd(a, 0) || rb_nb[p] !== exp_bsy(a, 0)) begin
                    n_fail++;
                    $display("FAIL rand_nobyp cyc=%0d p=%0d a=%0d got %h/%b want %h/%b",
                             cyc, p, a, rd_nb[p*XLEN +: XLEN], rb_nb[p], exp_rd(a, 0), exp_bsy(a, 0));
                end
            end
            n_checks++;
            if (int'(bc) !== exp_cnt() || int'(bc_nb) !== exp_cnt()) begin
                n_fail++; $display("FAIL rand_count cyc=%0d got %0d/%0d want %0d", cyc, bc, bc_nb, exp_cnt());
            end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_scoreboard();
        test_same_cycle();
        test_fill();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
